// File: rtl/memory_pkg.sv
// Shared constants and state type for the SRAM blanking/verify pair.
package memory_pkg;

  localparam int MEM_ADDR_W      = 18;
  localparam int MEM_DATA_W      = 32;
  localparam logic [MEM_DATA_W-1:0] BLANK_PATTERN = 32'h77553311;
  localparam int BLANK_LAST_ADDR = 262141;
  localparam int VERIFY_READ_LAT = 2;
  localparam int VERIFY_ERR_W    = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } verify_state_t;

endpackage

// File: rtl/memory_verify_if.sv
// Sequencer/SRAM-side bundle of the read-back checker; slave = checker, master = environment.
interface memory_verify_if
  import memory_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int ERR_W  = VERIFY_ERR_W
) ();

  logic              enable;
  logic              pause;
  logic [DATA_W-1:0] data_read;
  logic              rden;
  logic [ADDR_W-1:0] address;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  error_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_data;

  modport master (
    output enable, pause, data_read,
    input  rden, address, done, pass, error_count, first_err_addr, first_err_data
  );

  modport slave (
    input  enable, pause, data_read,
    output rden, address, done, pass, error_count, first_err_addr, first_err_data
  );

endinterface

// File: rtl/memory_verify_read_pipe.sv
// Pause-gated valid+address delay line matching the SRAM read latency.
module memory_verify_read_pipe
  import memory_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH  = VERIFY_READ_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              advance,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  output logic              tail_valid,
  output logic [ADDR_W-1:0] tail_addr,
  output logic              drain_last
);

  logic [DEPTH-1:0]  valid_r;
  logic [ADDR_W-1:0] addr_r [DEPTH];

  // Shift on unpaused cycles; a flush drops every in-flight read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) addr_r[i] <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else if (advance) begin
      valid_r[0] <= push_valid;
      addr_r[0]  <= push_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        addr_r[i]  <= addr_r[i-1];
      end
    end
  end

  assign tail_valid = valid_r[DEPTH-1];
  assign tail_addr  = addr_r[DEPTH-1];

  // True when at most the tail entry is still in flight.
  generate
    if (DEPTH > 1) begin : g_multi
      assign drain_last = ~|valid_r[DEPTH-2:0];
    end else begin : g_single
      assign drain_last = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/memory_verify.sv
// SRAM read-back checker: sweeps 0..LAST_ADDR comparing against the blank pattern.
// Optional build macro MEMORY_VERIFY_STOP_ON_ERROR_EN ends the sweep at the first mismatch.
module memory_verify
  import memory_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(BLANK_PATTERN),
  parameter int LAST_ADDR = BLANK_LAST_ADDR,
  parameter int READ_LAT  = VERIFY_READ_LAT,
  parameter int ERR_W     = VERIFY_ERR_W
) (
  input logic            clk,
  input logic            reset_n,
  memory_verify_if.slave bus
);

  verify_state_t     state_r;
  logic [ADDR_W-1:0] counter_r;
  logic [ADDR_W-1:0] address_r;
  logic              rden_r;
  logic              done_r;
  logic              pass_r;
  logic              err_seen_r;
  logic [ERR_W-1:0]  error_count_r;
  logic [ADDR_W-1:0] first_err_addr_r;
  logic [DATA_W-1:0] first_err_data_r;

  logic              busy_s;
  logic              abort_s;
  logic              start_s;
  logic              advance_s;
  logic              tail_valid_s;
  logic [ADDR_W-1:0] tail_addr_s;
  logic              drain_last_s;
  logic              tail_err_s;
  logic              stop_s;
  logic              flush_s;
  logic              push_s;
  logic [ERR_W-1:0]  err_cnt_next_s;

  // Abort beats pause; compares only happen on unpaused cycles of a live sweep.
  always_comb begin
    busy_s     = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
    abort_s    = busy_s && !bus.enable;
    start_s    = (state_r == ST_IDLE) && bus.enable;
    advance_s  = !bus.pause;
    tail_err_s = busy_s && bus.enable && advance_s && tail_valid_s &&
                 (bus.data_read != PATTERN);
    if (tail_err_s && (error_count_r != {ERR_W{1'b1}})) begin
      err_cnt_next_s = error_count_r + ERR_W'(1);
    end else begin
      err_cnt_next_s = error_count_r;
    end
`ifdef MEMORY_VERIFY_STOP_ON_ERROR_EN
    stop_s = tail_err_s;
`else
    stop_s = 1'b0;
`endif
    flush_s = abort_s || stop_s;
    push_s  = (state_r == ST_ISSUE) && !flush_s;
  end

  memory_verify_read_pipe #(
    .ADDR_W (ADDR_W),
    .DEPTH  (READ_LAT)
  ) u_read_pipe (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush_s),
    .advance    (advance_s),
    .push_valid (push_s),
    .push_addr  (counter_r),
    .tail_valid (tail_valid_s),
    .tail_addr  (tail_addr_s),
    .drain_last (drain_last_s)
  );

  // Sweep sequencer with registered strobe, address and handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      counter_r <= '0;
      address_r <= '0;
      rden_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rden_r    <= 1'b0;
          address_r <= '0;
          done_r    <= 1'b0;
          if (bus.enable) begin
            counter_r <= '0;
            pass_r    <= 1'b0;
            state_r   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort_s) begin
            state_r   <= ST_IDLE;
            rden_r    <= 1'b0;
            address_r <= '0;
          end else if (bus.pause) begin
            rden_r <= 1'b0;
          end else if (stop_s) begin
            state_r <= ST_DONE;
            rden_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= 1'b0;
          end else begin
            address_r <= counter_r;
            rden_r    <= 1'b1;
            counter_r <= counter_r + ADDR_W'(1);
            if (counter_r == ADDR_W'(LAST_ADDR)) state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          rden_r <= 1'b0;
          if (abort_s) begin
            state_r   <= ST_IDLE;
            address_r <= '0;
          end else if (advance_s && (stop_s || drain_last_s)) begin
            // The tail compare of this cycle is folded into the verdict.
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            pass_r  <= (err_cnt_next_s == '0) && !stop_s;
          end
        end
        ST_DONE: begin
          rden_r <= 1'b0;
          if (!bus.enable) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          rden_r    <= 1'b0;
          address_r <= '0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  // Result registers: cleared on start, updated by each failing compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error_count_r    <= '0;
      err_seen_r       <= 1'b0;
      first_err_addr_r <= '0;
      first_err_data_r <= '0;
    end else if (start_s) begin
      error_count_r    <= '0;
      err_seen_r       <= 1'b0;
      first_err_addr_r <= '0;
      first_err_data_r <= '0;
    end else if (tail_err_s) begin
      error_count_r <= err_cnt_next_s;
      if (!err_seen_r) begin
        err_seen_r       <= 1'b1;
        first_err_addr_r <= tail_addr_s;
        first_err_data_r <= bus.data_read;
      end
    end
  end

  assign bus.rden           = rden_r;
  assign bus.address        = address_r;
  assign bus.done           = done_r;
  assign bus.pass           = pass_r;
  assign bus.error_count    = error_count_r;
  assign bus.first_err_addr = first_err_addr_r;
  assign bus.first_err_data = first_err_data_r;

endmodule
